// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receive path.
package parity_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned ERR_CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } rx_state_e;

  // Parity bit the transmitter should have sent for a given running XOR.
  function automatic logic expected_parity(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// Registered running-XOR accumulator; clear and enable may be applied
// together so the first bit of a new frame loads directly.
module parity_accum (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q;
  logic acc_d;

  // Next value: optionally restart from zero, then fold in the new bit.
  always_comb begin
    acc_d = clear_i ? 1'b0 : acc_q;
    if (en_i) begin
      acc_d = acc_d ^ bit_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/parity_rx_checker.sv
// Serial frame receiver: collects DATA_BITS payload bits LSB first,
// checks the trailing parity bit and reports done/error/abort pulses.
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic        ODD_L = (ODD_PARITY != 0);
  // With a single payload bit the start beat is also the last payload beat.
  localparam logic        ONE_BIT = (DATA_BITS == 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 frame_done_q, frame_done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_abort_q, frame_abort_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic acc_clr_c;
  logic acc_en_c;
  logic acc_c;

  parity_accum u_accum (
    .clk     (clk),
    .reset   (reset),
    .clear_i (acc_clr_c),
    .en_i    (acc_en_c),
    .bit_i   (in_bit),
    .acc_o   (acc_c)
  );

  // Next-state, datapath and pulse generation; a start beat always wins.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    frame_done_d  = 1'b0;
    parity_err_d  = 1'b0;
    frame_abort_d = 1'b0;
    err_count_d   = err_count_q;
    acc_clr_c     = 1'b0;
    acc_en_c      = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        frame_abort_d = (state_q != ST_IDLE);
        shift_d       = DATA_BITS'(in_bit);
        bit_cnt_d     = CNT_W'(1);
        state_d       = ONE_BIT ? ST_PARITY : ST_DATA;
        acc_clr_c     = 1'b1;
        acc_en_c      = 1'b1;
      end else begin
        case (state_q)
          ST_DATA: begin
            shift_d   = shift_q | (DATA_BITS'(in_bit) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            acc_en_c  = 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
              state_d = ST_PARITY;
            end
          end
          ST_PARITY: begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            data_out_d   = shift_q;
            frame_done_d = 1'b1;
            parity_err_d = (in_bit != expected_parity(acc_c, ODD_L));
            acc_clr_c    = 1'b1;
            if (parity_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
          end
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end
        endcase
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      frame_done_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
      err_count_q   <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      frame_done_q  <= frame_done_d;
      parity_err_q  <= parity_err_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
      err_count_q   <= err_count_d;
    end
  end

  assign data_out    = data_out_q;
  assign frame_done  = frame_done_q;
  assign parity_err  = parity_err_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;
  assign err_count   = err_count_q;

endmodule
